shift_chain_sequencer: RTL and testbench
========================================

# shift_chain_sequencer

Sequencer that drives an external serial-in/serial-out shift-register chain. It accepts an N-bit word over a valid/ready handshake and presents the word LSB-first on the chain's serial input. It issues one shift strobe per bit period and captures the chain's serial output into an N-bit receive word. The block sits between the feature/data pipeline and the shift-register datapath, so that the datapath is only ever clocked forward under controlled, counted conditions.

## Interface
- N, 8, word length and number of shift strobes per frame (N ≥ 1)
- DIV, 4, clock cycles per bit period (DIV ≥ 1; DIV = 1 gives a strobe every cycle)

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_valid  input  1  in_data holds a word to shift
- in_ready  output  1  block accepts a word this cycle
- in_data  input  N  word to serialize, bit 0 sent first
- abort  input  1  synchronous cancel of the current frame
- serial_out  output  1  bit driven to the chain's signal_in
- shift_en  output  1  one-cycle strobe; the chain advances on the same clock edge
- serial_in  input  1  bit returned from the chain's signal_out
- busy  output  1  frame in progress (state SHIFT)
- out_valid  output  1  out_data holds a completed receive word
- out_ready  input  1  consumer accepts out_data
- out_data  output  N  captured receive word

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE and clears all registers.
- Reset values of the outputs:
  - in_ready = 1 (IDLE).
  - shift_en = 0, serial_out = 0, busy = 0.
  - out_valid = 0, out_data = 0.
- in_ready = (state == IDLE). It is a combinational decode of the state register only and never depends on in_valid.
- IDLE → SHIFT on in_valid & in_ready:
  - tx register ← in_data.
  - bit counter ← 0, prescaler ← 0, rx register ← 0.
- SHIFT:
  - Prescaler counts 0..DIV-1 and wraps.
  - shift_en = 1 exactly when prescaler == DIV-1.
  - serial_out = tx[0], held stable for the whole bit period.
- On each strobe edge:
  - tx shifts right: tx ← {1'b0, tx[N-1:1]}.
  - rx ← {serial_in, rx[N-1:1]}, so the new bit enters the MSB, matching the chain's shift direction.
  - bit counter increments.
- The strobe on which the bit counter reaches N-1 is the last one. On that edge the state goes SHIFT → DONE.
- DONE:
  - out_valid = 1, out_data = rx, both held until out_ready.
  - shift_en = 0, serial_out = 0.
- DONE → IDLE on out_valid & out_ready. out_data keeps its last value; only out_valid drops.
- abort:
  - Sampled in SHIFT and DONE. It forces IDLE on the next edge and drops out_valid.
  - An abort coinciding with the final strobe wins: the block goes to IDLE, and the chain still advances on that edge.
  - abort in IDLE has no effect and does not block an acceptance in the same cycle.
- Counter widths: bit counter $clog2(N+1) bits, prescaler $clog2(DIV+1) bits. No wrap beyond N or DIV-1.
- Asynchronous reset mid-frame:
  - All outputs immediately take their reset values.
  - No partial word is ever presented.
  - The external chain is not cleared by this block.

## Timing
- Acceptance at edge t (in_valid & in_ready sampled high).
- Strobes are asserted in the cycles ending at edges t+DIV, t+2·DIV, …, t+N·DIV.
- out_valid is high from edge t+N·DIV.
- Frame length is N·DIV cycles from acceptance to out_valid. The minimum frame-to-frame period is N·DIV+2 cycles with out_ready held high.
- serial_out changes only on strobe edges and on the acceptance edge.
- shift_en is never high outside SHIFT and never high for two consecutive cycles unless DIV = 1.
- All outputs are registered except in_ready, busy and shift_en. Those three are decodes of registered state and the prescaler only, with no input-to-output combinational path.

## Test plan
- Reset then idle:
  - N=8, DIV=4. Release reset and hold in_valid=0 for 20 cycles.
  - Required: in_ready=1, shift_en=0, out_valid=0 throughout.
- Loopback frame:
  - N=8, DIV=4. Connect serial_out → serial_in through an 8-bit chain and send 0xA5.
  - Required: exactly 8 strobes, 4 cycles apart; serial_out sequence 1,0,1,0,0,1,0,1; out_valid 32 cycles after acceptance.
  - Required: out_data equals the chain's initial contents shifted out, with 0xA5 left in the chain.
- Back-pressure:
  - Complete a frame with out_ready=0 for 10 cycles.
  - Required: out_valid and out_data stable, in_ready=0, no strobes; the cycle after out_ready=1, in_ready=1.
- Abort:
  - Assert abort after the 3rd strobe.
  - Required: IDLE next cycle, no further strobes, out_valid never asserted.
- Asynchronous reset:
  - Assert reset mid-cycle during SHIFT.
  - Required: all outputs at reset values before the next clock edge; a subsequent frame sent with 0x3C completes normally.
- DIV=1 boundary:
  - N=1, DIV=1, send 0x1.
  - Required: a single strobe in the cycle after acceptance; out_valid one cycle after acceptance; out_data = serial_in sampled at the strobe.

Source files
------------

// File: rtl/shift_chain_sequencer.sv
// Drives an external SISO shift-register chain: serializes a word LSB-first on serial_out,
// issues one counted shift strobe per bit period and captures the returned bits into out_data.
module shift_chain_sequencer #(
   parameter int N   = 8,
   parameter int DIV = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         abort,
   output logic         serial_out,
   output logic         shift_en,
   input  logic         serial_in,
   output logic         busy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data
);

   localparam int CNT_W = (N   > 1) ? $clog2(N + 1)   : 1;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic [PRE_W-1:0] pre;
   logic [N-1:0]     tx;
   logic [N-1:0]     rx;
   logic [N-1:0]     tx_nxt;
   logic [N-1:0]     rx_nxt;

   function automatic logic [N-1:0] tx_shift(input logic [N-1:0] word);
      return word >> 1;
   endfunction

   // Returned bit enters at the MSB, mirroring the chain's own shift direction.
   function automatic logic [N-1:0] rx_shift(input logic [N-1:0] word, input logic bit_in);
      logic [N-1:0] msb;
      msb        = '0;
      msb[N-1]   = bit_in;
      return (word >> 1) | msb;
   endfunction

   assign tx_nxt   = tx_shift(tx);
   assign rx_nxt   = rx_shift(rx, serial_in);

   assign in_ready = (state == IDLE);
   assign busy     = (state == SHIFT);
   assign shift_en = (state == SHIFT) && (pre == PRE_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         pre        <= '0;
         tx         <= '0;
         rx         <= '0;
         serial_out <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  tx         <= in_data;
                  serial_out <= in_data[0];
                  bit_cnt    <= '0;
                  pre        <= '0;
                  rx         <= '0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
               if (shift_en) begin
                  tx         <= tx_nxt;
                  rx         <= rx_nxt;
                  bit_cnt    <= bit_cnt + 1'b1;
                  serial_out <= tx_nxt[0];
                  // Abort on the final strobe still lets the chain advance but reports nothing.
                  if (abort) begin
                     state      <= IDLE;
                     serial_out <= 1'b0;
                  end else if (bit_cnt == LAST_BIT) begin
                     state      <= DONE;
                     out_valid  <= 1'b1;
                     out_data   <= rx_nxt;
                     serial_out <= 1'b0;
                  end
               end else if (abort) begin
                  state      <= IDLE;
                  serial_out <= 1'b0;
               end
            end
            DONE: begin
               if (abort || out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               out_valid  <= 1'b0;
               serial_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_chain_sequencer.sv
// Directed bench for shift_chain_sequencer: an 8-bit loopback chain on an N=8/DIV=4 instance
// and a second N=1/DIV=1 instance for the single-cycle boundary.
module tb_shift_chain_sequencer;
   localparam int N   = 8;
   localparam int DIV = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic         in_valid = 1'b0, in_ready, abort = 1'b0;
   logic [N-1:0] in_data = '0, out_data;
   logic         serial_out, shift_en, serial_in, busy, out_valid;
   logic         out_ready = 1'b0;

   logic         in_valid1 = 1'b0, in_ready1, serial_out1, shift_en1, busy1, out_valid1;
   logic         out_ready1 = 1'b0, serial_in1 = 1'b0;
   logic [0:0]   in_data1 = '0, out_data1;

   logic [7:0]   chain = '0, chain_init = '0;
   logic         chain_load = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   // External chain: new bit enters the MSB, signal_out is the LSB.
   always @(posedge clk) begin
      if (chain_load)    chain <= chain_init;
      else if (shift_en) chain <= {serial_out, chain[7:1]};
   end
   assign serial_in = chain[0];

   shift_chain_sequencer #(.N(N), .DIV(DIV)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .abort(abort), .serial_out(serial_out), .shift_en(shift_en), .serial_in(serial_in),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   shift_chain_sequencer #(.N(1), .DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .abort(1'b0), .serial_out(serial_out1), .shift_en(shift_en1), .serial_in(serial_in1),
      .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [7:0] init, input string nm);
      int ns, ov_c, sp_bad;
      logic [7:0] bits;
      chain_init = init;
      chain_load = 1'b1;
      tick();
      chain_load = 1'b0;
      check({nm, "_ready"}, in_ready, 1);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({nm, "_busy"}, busy, 1);
      ns = 0; ov_c = -1; sp_bad = 0; bits = '0;
      for (int c = 0; c < N * DIV + 8; c++) begin
         if (out_valid) begin
            ov_c = c;
            break;
         end
         if (shift_en) begin
            if (c + 1 != DIV * (ns + 1)) sp_bad++;
            if (ns < N) bits[ns] = serial_out;
            ns++;
         end
         tick();
      end
      check({nm, "_strobes"}, ns, N);
      check({nm, "_spacing"}, sp_bad, 0);
      check({nm, "_serial_bits"}, bits, d);
      check({nm, "_latency"}, ov_c, N * DIV);
      check({nm, "_out_data"}, out_data, init);
      check({nm, "_chain"}, chain, d);
   endtask

   initial begin
      int bad_rdy, bad_se, bad_ov, bad_od, ns;

      // Reset held, then released: idle for 20 cycles.
      tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_shift_en", shift_en, 0);
      check("rst_serial_out", serial_out, 0);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      reset = 1'b0;
      bad_rdy = 0; bad_se = 0; bad_ov = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (in_ready !== 1'b1) bad_rdy++;
         if (shift_en !== 1'b0) bad_se++;
         if (out_valid !== 1'b0) bad_ov++;
      end
      check("idle_in_ready", bad_rdy, 0);
      check("idle_shift_en", bad_se, 0);
      check("idle_out_valid", bad_ov, 0);

      // Loopback frame 0xA5 against chain preloaded with 0x5E.
      send_frame(8'hA5, 8'h5E, "loop");

      // Back-pressure: hold out_ready low for 10 cycles.
      bad_rdy = 0; bad_se = 0; bad_ov = 0; bad_od = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (in_ready !== 1'b0) bad_rdy++;
         if (shift_en !== 1'b0) bad_se++;
         if (out_valid !== 1'b1) bad_ov++;
         if (out_data !== 8'h5E) bad_od++;
      end
      check("bp_in_ready", bad_rdy, 0);
      check("bp_strobes", bad_se, 0);
      check("bp_out_valid", bad_ov, 0);
      check("bp_out_data", bad_od, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("release_in_ready", in_ready, 1);
      check("release_out_valid", out_valid, 0);
      check("release_out_data_kept", out_data, 8'h5E);

      // Abort after the 3rd strobe; abort in IDLE must not block acceptance.
      abort    = 1'b1;
      in_data  = 8'h0F;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      abort    = 1'b0;
      check("abort_idle_accept", busy, 1);
      ns = 0;
      for (int c = 0; c < 40 && ns < 3; c++) begin
         if (shift_en) ns++;
         tick();
      end
      check("abort_pre_strobes", ns, 3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_serial_out", serial_out, 0);
      bad_se = 0; bad_ov = 0;
      for (int i = 0; i < 40; i++) begin
         if (shift_en) bad_se++;
         if (out_valid) bad_ov++;
         tick();
      end
      check("abort_no_strobes", bad_se, 0);
      check("abort_no_out_valid", bad_ov, 0);

      // Asynchronous reset asserted mid-cycle during SHIFT.
      in_data  = 8'h3C;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("arst_pre_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_in_ready", in_ready, 1);
      check("arst_busy", busy, 0);
      check("arst_shift_en", shift_en, 0);
      check("arst_serial_out", serial_out, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_out_data", out_data, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      send_frame(8'h3C, 8'h96, "post_rst");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("post_rst_idle", in_ready, 1);

      // N=1, DIV=1: strobe in the cycle right after acceptance.
      serial_in1 = 1'b1;
      in_data1   = 1'b1;
      in_valid1  = 1'b1;
      tick();
      in_valid1  = 1'b0;
      check("d1_strobe", shift_en1, 1);
      check("d1_serial_out", serial_out1, 1);
      check("d1_early_out_valid", out_valid1, 0);
      tick();
      check("d1_out_valid", out_valid1, 1);
      check("d1_out_data", out_data1, 1);
      check("d1_no_strobe", shift_en1, 0);
      out_ready1 = 1'b1;
      tick();
      check("d1_idle", in_ready1, 1);
      serial_in1 = 1'b0;
      in_data1   = 1'b0;
      in_valid1  = 1'b1;
      tick();
      in_valid1  = 1'b0;
      check("d1b_strobe", shift_en1, 1);
      check("d1b_serial_out", serial_out1, 0);
      tick();
      check("d1b_out_valid", out_valid1, 1);
      check("d1b_out_data", out_data1, 0);
      out_ready1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
